// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Registered immediate extender for the decode path. An instruction word and
//   its immediate-select code arrive over a valid/ready handshake; the
//   sign-extended immediate is computed at the input, stored, and presented one
//   cycle later from registers. A main register (M) drives the outputs and a
//   skid register (K) absorbs one extra entry, so in_ready depends only on
//   registered state and never combinationally on out_ready.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   flush     : synchronous flush, discards all held entries
//   in_valid  : instr/immsrc/in_tag valid this cycle
//   in_ready  : block can accept an entry this cycle
//   instr     : 32-bit instruction word
//   immsrc    : immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   in_tag    : opaque side-band tag
//   out_valid : immext/out_tag/illegal valid
//   out_ready : consumer accepts the presented entry
//   immext    : XLEN-bit extended immediate
//   out_tag   : tag of the presented entry
//   illegal   : presented entry used an unsupported immsrc
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_S = 3'b001,
    SEL_B = 3'b010,
    SEL_J = 3'b011,
    SEL_U = 3'b100
  } imm_sel_e;

  // Main (output) register
  logic             m_valid;
  logic [XLEN-1:0]  m_imm;
  logic [TAG_W-1:0] m_tag;
  logic             m_ill;

  // Skid register
  logic             k_valid;
  logic [XLEN-1:0]  k_imm;
  logic [TAG_W-1:0] k_tag;
  logic             k_ill;

  // Extension computed at the input
  logic [63:0]      ext_full;
  logic [XLEN-1:0]  in_imm;
  logic             in_ill;
  logic             sgn;
  logic             accept;
  logic             m_free;

  // Always build the 64-bit form and keep the low XLEN bits; for XLEN=32 the
  // U-type result is simply {instr[31:12], 12'b0}.
  always_comb begin
    sgn      = instr[31];
    ext_full = '0;
    in_ill   = 1'b0;
    case (immsrc)
      SEL_I:   ext_full = {{52{sgn}}, instr[31:20]};
      SEL_S:   ext_full = {{52{sgn}}, instr[31:25], instr[11:7]};
      SEL_B:   ext_full = {{52{sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_J:   ext_full = {{44{sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_U:   ext_full = {{32{sgn}}, instr[31:12], 12'b0};
      default: begin
        ext_full = '0;
        in_ill   = 1'b1;
      end
    endcase
    in_imm = ext_full[XLEN-1:0];
  end

  assign in_ready  = !k_valid;
  assign accept    = in_valid && in_ready;
  // M can take a new entry when it is empty or being drained this edge
  assign m_free    = !m_valid || out_ready;

  assign out_valid = m_valid;
  assign immext    = m_imm;
  assign out_tag   = m_tag;
  assign illegal   = m_ill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_imm   <= '0;
      m_tag   <= '0;
      m_ill   <= 1'b0;
      k_valid <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
      k_ill   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (m_free) begin
      if (k_valid) begin
        m_valid <= 1'b1;
        m_imm   <= k_imm;
        m_tag   <= k_tag;
        m_ill   <= k_ill;
        if (accept) begin
          k_imm <= in_imm;
          k_tag <= in_tag;
          k_ill <= in_ill;
        end
        k_valid <= accept;
      end else begin
        m_valid <= accept;
        if (accept) begin
          m_imm <= in_imm;
          m_tag <= in_tag;
          m_ill <= in_ill;
        end
        k_valid <= 1'b0;
      end
    end else if (accept) begin
      // M is stalled: the new entry waits in K behind it
      k_valid <= 1'b1;
      k_imm   <= in_imm;
      k_tag   <= in_tag;
      k_ill   <= in_ill;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe. Two instances (XLEN=32 and XLEN=64) share
// the same stimulus so both widths are checked on every vector.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] immext32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] immext64;
  logic [7:0]  out_tag64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .immext(immext32), .out_tag(out_tag32), .illegal(illegal32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .immext(immext64), .out_tag(out_tag64), .illegal(illegal64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
    in_valid = 1'b1;
    instr    = i;
    immsrc   = s;
    in_tag   = t;
  endtask

  // Checks the presented entry on both widths
  task automatic check_out(input string tag, input logic v, input logic [31:0] e32,
                           input logic [63:0] e64, input logic [7:0] t, input logic ill);
    check({tag, ".v32"},   out_valid32, v);
    check({tag, ".v64"},   out_valid64, v);
    if (v) begin
      check({tag, ".imm32"}, immext32, e32);
      check({tag, ".imm64"}, immext64, e64);
      check({tag, ".tag32"}, out_tag32, t);
      check({tag, ".tag64"}, out_tag64, t);
      check({tag, ".ill32"}, illegal32, ill);
      check({tag, ".ill64"}, illegal64, ill);
    end
  endtask

  task automatic check_rdy(input string tag, input logic r);
    check({tag, ".rdy32"}, in_ready32, r);
    check({tag, ".rdy64"}, in_ready64, r);
  endtask

  // Send one entry with out_ready=1 and check it one cycle later
  task automatic single(input string tag, input logic [31:0] i, input logic [2:0] s,
                        input logic [7:0] t, input logic [31:0] e32,
                        input logic [63:0] e64, input logic ill);
    offer(i, s, t);
    tick();
    in_valid = 1'b0;
    check_out(tag, 1'b1, e32, e64, t, ill);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    immsrc    = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    #12;
    check("rst.v32",   out_valid32, 1'b0);
    check("rst.imm64", immext64, 64'h0);
    check("rst.tag32", out_tag32, 8'h00);
    check("rst.ill32", illegal32, 1'b0);
    check_rdy("rst", 1'b1);
    // inputs ignored while reset is high
    offer(32'hFFF00093, 3'b000, 8'h55);
    tick();
    check("rst_ign.v32", out_valid32, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Format coverage, out_ready=1
    single("i_type", 32'hFFF00093, 3'b000, 8'h05, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    single("s_type", 32'hFE112E23, 3'b001, 8'h06, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    single("b_type", 32'hFE000EE3, 3'b010, 8'h07, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    single("j_type", 32'h0080006F, 3'b011, 8'h08, 32'h00000008, 64'h0000000000000008, 1'b0);
    single("u_type", 32'h800000B7, 3'b100, 8'h09, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    single("u_pos",  32'h12345037, 3'b100, 8'h0A, 32'h12345000, 64'h0000000012345000, 1'b0);
    single("ill101", 32'hFFFFFFFF, 3'b101, 8'h0B, 32'h0, 64'h0, 1'b1);
    single("ill111", 32'hFFF00093, 3'b111, 8'h0C, 32'h0, 64'h0, 1'b1);
    single("i_pos",  32'h7FF00093, 3'b000, 8'h0D, 32'h000007FF, 64'h00000000000007FF, 1'b0);
    tick();
    check_out("drained", 1'b0, '0, '0, '0, 1'b0);

    // Backpressure: tags 1,2,3 back-to-back with out_ready=0
    out_ready = 1'b0;
    offer(32'h00100093, 3'b000, 8'h01);
    tick();
    check_rdy("bp.a1", 1'b1);
    offer(32'h00200093, 3'b000, 8'h02);
    tick();
    check_rdy("bp.a2", 1'b0);
    offer(32'h00300093, 3'b000, 8'h03);
    tick();
    check_out("bp.hold1", 1'b1, 32'h1, 64'h1, 8'h01, 1'b0);
    check_rdy("bp.full", 1'b0);
    tick();
    check_out("bp.hold1b", 1'b1, 32'h1, 64'h1, 8'h01, 1'b0);
    out_ready = 1'b1;
    tick();
    check_out("bp.out2", 1'b1, 32'h2, 64'h2, 8'h02, 1'b0);
    check_rdy("bp.reopen", 1'b1);
    tick();
    in_valid = 1'b0;
    check_out("bp.out3", 1'b1, 32'h3, 64'h3, 8'h03, 1'b0);
    tick();
    check_out("bp.empty", 1'b0, '0, '0, '0, 1'b0);

    // Flush with M and K full plus an offered input
    out_ready = 1'b0;
    offer(32'h01100093, 3'b000, 8'h11);
    tick();
    offer(32'h01200093, 3'b000, 8'h12);
    tick();
    check_rdy("fl.full", 1'b0);
    offer(32'h01300093, 3'b000, 8'h13);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    check_out("fl.empty", 1'b0, '0, '0, '0, 1'b0);
    check_rdy("fl.rdy", 1'b1);
    // in_valid still high here with in_ready=1 would accept; drop it first
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("fl.gone", 1'b0, '0, '0, '0, 1'b0);

    // Asynchronous reset mid-cycle with M and K full
    out_ready = 1'b0;
    offer(32'hFFF00093, 3'b000, 8'h21);
    tick();
    offer(32'h80000037, 3'b100, 8'h22);
    tick();
    in_valid = 1'b0;
    check_out("ar.pre", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h21, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("ar.v32",   out_valid32, 1'b0);
    check("ar.v64",   out_valid64, 1'b0);
    check("ar.imm32", immext32, 32'h0);
    check("ar.imm64", immext64, 64'h0);
    check("ar.tag32", out_tag32, 8'h00);
    check("ar.ill64", illegal64, 1'b0);
    check_rdy("ar", 1'b1);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    single("ar.after", 32'hFFF00093, 3'b000, 8'h07, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    tick();
    check_out("ar.end", 1'b0, '0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, registered successor to the combinational immediate extender in the decode path. It accepts an instruction word plus immediate-select code over a valid/ready handshake and produces the sign-extended immediate one cycle later. It adds U-type support, XLEN generalisation, a tag side-band and a 2-entry skid buffer so decode can stall without a combinational ready path. It also supports a pipeline flush and illegal-select flagging.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills to XLEN
TAG_W, 8, width of opaque side-band tag carried alongside each entry (e.g. rd/ROB index); minimum 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush; discards all held entries
in_valid  input  1  instr/immsrc/in_tag valid this cycle
in_ready  output  1  block can accept an entry this cycle
instr  input  32  instruction word
immsrc  input  3  immediate format select
in_tag  input  TAG_W  side-band tag
out_valid  output  1  immext/out_tag/illegal valid
out_ready  input  1  consumer accepts output this cycle
immext  output  XLEN  extended immediate
out_tag  output  TAG_W  tag of the presented entry
illegal  output  1  presented entry had an unsupported immsrc

Behaviour:
- Formats (s = instr[31], replicated to fill XLEN):
  - 000 I: {s.., instr[31:20]}
  - 001 S: {s.., instr[31:25], instr[11:7]}
  - 010 B: {s.., instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: {s.., instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {s.., instr[31:12], 12'b0}; the upper 32 bits are sign fill only when XLEN=64
  - 101/110/111: immext = 0, illegal = 1
- Extension is computed at the input and stored; outputs come directly from registers, with no combinational path from instr to immext.
- Storage: main register (M) drives the outputs; skid register (K) holds one more entry. Each has its own valid bit.
- in_ready = !K.valid, registered-derived only; it never depends combinationally on out_ready.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready.
- Per-edge update (no flush):
  - M empty or draining: M loads K if K valid, else the accepted input. K loads the accepted input when K supplied M and an input was also accepted; otherwise K clears.
  - M holding (out_valid && !out_ready): an accepted input goes to K.
- Ordering is strict FIFO. No entry is lost or duplicated.
- Latency is 1 cycle from accept to out_valid when the block is empty. Throughput is 1 per cycle while out_ready=1.
- Flush: on the next edge M.valid=0 and K.valid=0. An input offered in the flush cycle is discarded. A drain in the flush cycle still counts as consumed. in_ready=1 the cycle after.
- Reset (asynchronous, at any time including mid-transfer): M.valid=0, K.valid=0, immext=0, out_tag=0, illegal=0, out_valid=0. in_ready is 1 while reset is asserted and after it deasserts. Inputs are ignored while reset=1.
- out_valid must not drop, and immext/out_tag/illegal must not change, while out_valid=1 && out_ready=0 (except on flush or reset).
- Data registers may hold stale values when their valid bit is 0, except after reset, where they are 0.

Test Plan:
- I-type, XLEN=32: instr=0xFFF00093, immsrc=000, tag=0x05, out_ready=1 -> next cycle out_valid=1, immext=0xFFFFFFFF, out_tag=0x05, illegal=0.
- B-type: instr=0xFE000EE3, immsrc=010 -> immext=0xFFFFFFFC. J-type: instr=0x0080006F, immsrc=011 -> immext=0x00000008.
- U-type, XLEN=64: instr=0x800000B7, immsrc=100 -> immext=0xFFFFFFFF80000000. Illegal: immsrc=101 -> immext=0, illegal=1.
- Backpressure: out_ready=0, issue tags 1,2,3 back-to-back -> 1 held in M, 2 in K, in_ready=0 from the cycle after tag 2's accept, so 3 is held by the source. Raise out_ready -> tags 1,2,3 emerge on consecutive cycles with no gap, duplicate or loss.
- Flush with M and K full, plus a new input offered the same cycle -> next cycle out_valid=0 and in_ready=1; the offered input never appears.
- Assert reset asynchronously mid-cycle with M/K full -> outputs go to zero and out_valid=0 immediately, without waiting for clk. After deassertion, a new I-type entry completes with 1-cycle latency.
